// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwards, transforms and skid-buffers adder operands in a 2-entry FIFO
module alu_operand_stage #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_fwd,
  input  logic             in_b_fwd,
  input  logic [WIDTH-1:0] fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sub,
  output logic [1:0]       out_op,
  output logic [1:0]       occupancy
);
  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic             mem_sub [2];
  logic [1:0]       mem_op [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] a, b, t_a, t_b;
  logic             t_sub, push, pop;
  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_a     = mem_a[rd_ptr];
  assign out_b     = mem_b[rd_ptr];
  assign out_sub   = mem_sub[rd_ptr];
  assign out_op    = mem_op[rd_ptr];
  assign occupancy = count;
  // forward mux first, then the op transform that feeds the adder's A, B and carry-in
  always_comb begin
    a     = in_a_fwd ? fwd_data : in_a;
    b     = in_b_fwd ? fwd_data : in_b;
    t_a   = (in_op == 2'b11) ? '0 : a;
    t_b   = (in_op == 2'b00) ? b : (in_op == 2'b10) ? '0 : ~b;
    t_sub = in_op != 2'b00;
  end
  // circular buffer state; flush drops everything and wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a   <= '{default: '0};
      mem_b   <= '{default: '0};
      mem_sub <= '{default: 1'b0};
      mem_op  <= '{default: 2'b00};
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem_a[wr_ptr]   <= t_a;
        mem_b[wr_ptr]   <= t_b;
        mem_sub[wr_ptr] <= t_sub;
        mem_op[wr_ptr]  <= in_op;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of forwarding, transforms, FIFO order, flush and reset
module tb_alu_operand_stage;
  logic       clk = 1'b0, rst_n, flush, in_valid, in_ready, in_a_fwd, in_b_fwd;
  logic       out_valid, out_ready, out_sub;
  logic [1:0] in_op, out_op, occupancy;
  logic [2:0] in_a, in_b, fwd_data, out_a, out_b;
  int checks = 0, errors = 0;

  alu_operand_stage #(.WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_a_fwd(in_a_fwd), .in_b_fwd(in_b_fwd),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_sub(out_sub), .out_op(out_op), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic af, input logic bf, input logic [2:0] fd);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    in_a_fwd = af; in_b_fwd = bf; fwd_data = fd;
  endtask

  task automatic pop_one();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(2'b00, 3'd5, 3'd5, 1'b0, 1'b0, 3'd0);
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_sub", out_sub, 0);
    chk("rst_op", out_op, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    // SUB 3-2
    drive(2'b01, 3'd3, 3'd2, 1'b0, 1'b0, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("sub_valid", out_valid, 1);
    chk("sub_a", out_a, 3);
    chk("sub_b", out_b, 5);
    chk("sub_sub", out_sub, 1);
    chk("sub_op", out_op, 1);
    chk("sub_occ", occupancy, 1);
    pop_one();
    chk("sub_pop_occ", occupancy, 0);
    // NEG b=3
    drive(2'b11, 3'd5, 3'd3, 1'b0, 1'b0, 3'd0);
    tick();
    chk("neg_a", out_a, 0);
    chk("neg_b", out_b, 4);
    chk("neg_sub", out_sub, 1);
    pop_one();
    // INC a=7
    drive(2'b10, 3'd7, 3'd5, 1'b0, 1'b0, 3'd0);
    tick();
    chk("inc_a", out_a, 7);
    chk("inc_b", out_b, 0);
    chk("inc_sub", out_sub, 1);
    pop_one();
    // forwarding on B, then on A
    drive(2'b00, 3'd1, 3'd2, 1'b0, 1'b1, 3'd6);
    tick();
    chk("fwdb_a", out_a, 1);
    chk("fwdb_b", out_b, 6);
    chk("fwdb_sub", out_sub, 0);
    pop_one();
    drive(2'b01, 3'd5, 3'd1, 1'b1, 1'b0, 3'd2);
    tick();
    chk("fwda_a", out_a, 2);
    chk("fwda_b", out_b, 6);
    pop_one();
    // fill with out_ready low, third offer held off
    drive(2'b00, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("fill1_ready", in_ready, 1);
    drive(2'b00, 3'd2, 3'd2, 1'b0, 1'b0, 3'd0);
    tick();
    chk("fill2_occ", occupancy, 2);
    chk("fill2_ready", in_ready, 0);
    drive(2'b00, 3'd3, 3'd3, 1'b0, 1'b0, 3'd0);
    tick();
    chk("full_occ", occupancy, 2);
    chk("stall_a", out_a, 1);
    chk("stall_b", out_b, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("order2_a", out_a, 2);
    chk("order2_occ", occupancy, 1);
    tick();
    chk("drain_occ", occupancy, 0);
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    // push/pop together at count 1
    drive(2'b00, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_a = 3'(i);
      tick();
      chk("pp_occ", occupancy, 1);
      chk("pp_a", out_a, 8'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("pp_drain", occupancy, 0);
    out_ready = 1'b0;
    // flush with a full stage and an offer pending
    drive(2'b00, 3'd4, 3'd4, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    chk("pre_flush_occ", occupancy, 2);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_ready", in_ready, 1);
    // async reset mid-stream
    drive(2'b01, 3'd6, 3'd1, 1'b0, 1'b0, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_a", out_a, 0);
    chk("arst_b", out_b, 0);
    chk("arst_sub", out_sub, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
